// File: rtl/mem_scan_pkg.sv
//------------------------------------------------------------------------------
// Module  : mem_scan_pkg
// Brief   : Shared FSM state type and default widths for the memory scan
//           initiator.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_scan_pkg;

    localparam int c_DEF_ADDR_W    = 64;
    localparam int c_DEF_DATA_W    = 64;
    localparam int c_DEF_CNT_W     = 16;
    localparam int c_DEF_MAX_OUTST = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_scan_credit.sv
//------------------------------------------------------------------------------
// Module  : mem_scan_credit
// Brief   : Outstanding-read counter and request issue permit.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_scan_credit
    import mem_scan_pkg::*;
#(
    parameter int MAX_OUTST = c_DEF_MAX_OUTST
) (
    input  logic clk,
    input  logic rst,
    input  logic issue_en,
    input  logic req_ready,
    input  logic rsp_valid,
    output logic req_valid,
    output logic rsp_accept,
    output logic outst_zero
);

    localparam int c_OUT_W = $clog2(MAX_OUTST + 1);

    logic [c_OUT_W-1:0] r_outst;
    logic               w_fire;

    assign req_valid  = issue_en && (r_outst < c_OUT_W'(MAX_OUTST));
    assign w_fire     = req_valid && req_ready;
    // A response with nothing in flight is not ours and must not underflow
    assign rsp_accept = rsp_valid && (r_outst != '0);
    assign outst_zero = (r_outst == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outst <= '0;
        end else if (w_fire && !rsp_accept) begin
            r_outst <= r_outst + c_OUT_W'(1);
        end else if (!w_fire && rsp_accept) begin
            r_outst <= r_outst - c_OUT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_scan_initiator.sv
//------------------------------------------------------------------------------
// Module  : mem_scan_initiator
// Brief   : Issues a run of sequential reads and checks returned data against
//           the address; compare logic present only with MEM_SCAN_CHECK_EN.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_scan_initiator
    import mem_scan_pkg::*;
#(
    parameter int ADDR_W    = c_DEF_ADDR_W,
    parameter int DATA_W    = c_DEF_DATA_W,
    parameter int CNT_W     = c_DEF_CNT_W,
    parameter int MAX_OUTST = c_DEF_MAX_OUTST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  rsp_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              spur_rsp
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_rsp_count;
    logic              r_spur;
    logic              w_start_ok;
    logic              w_req_fire;
    logic              w_last_fire;
    logic              w_rsp_accept;
    logic              w_outst_zero;

    mem_scan_credit #(
        .MAX_OUTST (MAX_OUTST)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .issue_en   (r_state == ST_ISSUE),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .req_valid  (req_valid),
        .rsp_accept (w_rsp_accept),
        .outst_zero (w_outst_zero)
    );

    assign w_start_ok  = (r_state == ST_IDLE) && start;
    assign w_req_fire  = req_valid && req_ready;
    assign w_last_fire = w_req_fire && (r_issued == (r_num - CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = (num_words == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (w_last_fire) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_outst_zero && (r_rsp_count == r_num)) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base      <= '0;
            r_num       <= '0;
            r_issued    <= '0;
            r_rsp_count <= '0;
            r_spur      <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_base      <= base_addr;
                r_num       <= num_words;
                r_issued    <= '0;
                r_rsp_count <= '0;
                r_spur      <= 1'b0;
            end else begin
                if (w_req_fire) r_issued <= r_issued + CNT_W'(1);
                if (w_rsp_accept && (r_rsp_count != '1)) r_rsp_count <= r_rsp_count + CNT_W'(1);
            end
            if (rsp_valid && !w_rsp_accept) r_spur <= 1'b1;
        end
    end

    assign req_addr  = r_base + ADDR_W'(r_issued);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign rsp_count = r_rsp_count;
    assign spur_rsp  = r_spur;

`ifdef MEM_SCAN_CHECK_EN
    logic [ADDR_W-1:0] w_exp_addr;
    logic              w_mismatch;
    logic [CNT_W-1:0]  r_err_count;
    logic [ADDR_W-1:0] r_first_err;

    // Responses return in order, so the k-th accepted one belongs to base+k
    assign w_exp_addr = r_base + ADDR_W'(r_rsp_count);
    assign w_mismatch = w_rsp_accept && (rsp_data != DATA_W'(w_exp_addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
            r_first_err <= '0;
        end else if (w_start_ok) begin
            r_err_count <= '0;
            r_first_err <= '0;
        end else if (w_mismatch) begin
            if (r_err_count == '0) r_first_err <= w_exp_addr;
            if (r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err;
`else
    logic w_unused_rsp_data;
    assign w_unused_rsp_data = ^rsp_data;
    assign err_count         = '0;
    assign first_err_addr    = '0;
`endif

endmodule

`default_nettype wire

// File: doc/mem_scan_initiator.md
MEM_SCAN_INITIATOR -- requirements
Module: mem_scan_initiator

Interface
REQ-001 Parameter ADDR_W, default 64, request address width.
REQ-002 Parameter DATA_W, default 64, response data width.
REQ-003 Parameter CNT_W, default 16, width of word count and all counters.
REQ-004 Parameter MAX_OUTST, default 4, maximum outstanding reads, range 1..15.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock, all logic on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  launch a scan; sampled only in IDLE.
REQ-009 base_addr  in  ADDR_W  first read address; captured on accepted start.
REQ-010 num_words  in  CNT_W  number of reads; captured on accepted start.
REQ-011 req_valid  out  1  read request valid.
REQ-012 req_addr  out  ADDR_W  read address.
REQ-013 req_ready  in  1  responder accepts request.
REQ-014 rsp_valid  in  1  read data valid (in order, no backpressure).
REQ-015 rsp_data  in  DATA_W  read data.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse at scan end.
REQ-018 rsp_count  out  CNT_W  responses received this scan.
REQ-019 err_count  out  CNT_W  data mismatches this scan.
REQ-020 first_err_addr  out  ADDR_W  address of first mismatch.
REQ-021 spur_rsp  out  1  sticky; rsp_valid seen with zero outstanding.

Function
REQ-022 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-023 IDLE->ISSUE on start; start with num_words==0 goes IDLE->DONE.
REQ-024 ISSUE->DRAIN on the cycle the last request handshakes (req_valid&&req_ready).
REQ-025 DRAIN->DONE on the cycle outstanding reaches 0 and rsp_count==num_words.
REQ-026 DONE->IDLE unconditionally after one cycle; done is high only in DONE.
REQ-027 start outside IDLE is ignored.
REQ-028 req_valid = ISSUE && outstanding<MAX_OUTST; req_addr = base_addr + issued index, modulo 2^ADDR_W.
REQ-029 req_addr and req_valid hold stable while req_valid && !req_ready.
REQ-030 Outstanding counter: +1 on request handshake, -1 on rsp_valid, unchanged when both occur in the same cycle.
REQ-031 rsp_valid with outstanding==0 is discarded and sets spur_rsp until next accepted start or rst.
REQ-032 Expected data for response k is base_addr + k zero-extended or truncated to DATA_W.
REQ-033 rsp_count and err_count saturate at 2^CNT_W-1.
REQ-034 first_err_addr is written only on the first mismatch of a scan.
REQ-035 Accepted start clears rsp_count, err_count, first_err_addr and spur_rsp.
REQ-036 Result outputs hold their values in IDLE until the next accepted start.

Reset
REQ-037 rst at any time, including mid-scan, forces IDLE and clears outstanding.
REQ-038 rst zeroes every output; responses arriving after reset count as spurious.

Configuration
REQ-039 With macro MEM_SCAN_CHECK_EN defined, the REQ-032..034 compare logic is compiled in.
REQ-040 Without MEM_SCAN_CHECK_EN, err_count and first_err_addr are tied to 0 and no comparator exists; sequencing is unchanged.

Structure
REQ-041 Package mem_scan_pkg holds the state enum typedef and default width constants.
REQ-042 One sub-module, mem_scan_credit, holds the outstanding counter and issue-permit logic.

Verification
REQ-043 Responder with 1-cycle latency and data==addr; base=0x10, num=8 -> addresses 0x10..0x17, rsp_count=8, err_count=0, one done pulse.
REQ-044 Responder holds req_ready low for 3 cycles -> req_addr stable throughout; outstanding never exceeds 4.
REQ-045 Data at address 0x13 corrupted to 0xFF -> err_count=1, first_err_addr=0x13 (err_count=0 without MEM_SCAN_CHECK_EN).
REQ-046 base=0xFFFF_FFFF_FFFF_FFFE, num=4 -> addresses ...FE, ...FF, 0x0, 0x1, err_count=0.
REQ-047 num=0 -> done on the cycle after start, no req_valid; rsp_valid in IDLE -> spur_rsp=1.
REQ-048 rst asserted mid-scan after 3 requests -> next cycle IDLE, all outputs 0; a new scan completes normally.
